// File: rtl/shift_encode_pipe_if.sv
// Stream bundle for shift_encode_pipe: operand/tag in, shifted word/encoder result/tag out.
// The slave modport is the pipeline itself; the master modport is the operand source plus the result consumer.
interface shift_encode_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    localparam int SH_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SH_W-1:0]  in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_shifted;
    logic [SH_W-1:0]  out_pe;
    logic             out_pe_vld;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_shifted, out_pe, out_pe_vld, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_shifted, out_pe, out_pe_vld, out_tag
    );
endinterface

// File: rtl/shift_encode_pipe.sv
// Two-stage pipeline: stage 1 barrel-shifts (SLL/SRL/SRA/ROR), stage 2 priority-encodes the
// highest set bit. Valid/ready on both sides with full throughput; a tag rides along with each beat.
module shift_encode_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_encode_pipe_if.slave    bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic [SH_W-1:0]  s2_pe;
    logic             s2_pe_vld;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0]   shifted_next;
    logic [2*WIDTH-1:0] rot_wide;
    logic [SH_W-1:0]  pe_next;
    logic             pe_vld_next;

    // A stage may load whenever its register is empty or its content moves on in the same cycle.
    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    always_comb begin
        rot_wide     = {bus.in_data, bus.in_data} >> bus.in_shamt;
        shifted_next = bus.in_data;
        case (bus.in_mode)
            MODE_SLL: shifted_next = bus.in_data << bus.in_shamt;
            MODE_SRL: shifted_next = bus.in_data >> bus.in_shamt;
            MODE_SRA: shifted_next = $signed(bus.in_data) >>> bus.in_shamt;
            MODE_ROR: shifted_next = rot_wide[WIDTH-1:0];
            default:  shifted_next = bus.in_data;
        endcase
    end

    // Ascending scan so the highest set bit is the last to write.
    always_comb begin
        pe_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_data[i]) begin
                pe_next = SH_W'(i);
            end
        end
        pe_vld_next = |s1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_pe     <= '0;
            s2_pe_vld <= 1'b0;
            s2_tag    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data <= shifted_next;
                    s1_tag  <= bus.in_tag;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data   <= s1_data;
                    s2_pe     <= pe_next;
                    s2_pe_vld <= pe_vld_next;
                    s2_tag    <= s1_tag;
                end
            end
        end
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = s2_valid;
    assign bus.out_shifted = s2_data;
    assign bus.out_pe      = s2_pe;
    assign bus.out_pe_vld  = s2_pe_vld;
    assign bus.out_tag     = s2_tag;
endmodule

// File: tb/tb_shift_encode_pipe.sv
// Directed bench for shift_encode_pipe: single beats in every mode, backpressure, a
// randomized stream against a bitwise reference model, mid-stream reset and a 16-bit instance.
module tb_shift_encode_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [7:0] sh;
        logic [2:0] pe;
        logic       vld;
        logic [3:0] tag;
    } beat_t;

    beat_t sb[$];

    shift_encode_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();
    shift_encode_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();

    shift_encode_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    shift_encode_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic [2:0] shamt, input logic [1:0] mode,
                                 input logic [3:0] tag);
        bus8.in_valid = valid;
        bus8.in_data  = data;
        bus8.in_shamt = shamt;
        bus8.in_mode  = mode;
        bus8.in_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    // Reference shift written bit by bit rather than with shift operators.
    function automatic logic [7:0] modelShift(input logic [7:0] d, input int s, input logic [1:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = 1'b0;
            case (m)
                2'b00: if (i - s >= 0) r[i] = d[i-s];
                2'b01: if (i + s < 8)  r[i] = d[i+s];
                2'b10: if (i + s < 8)  r[i] = d[i+s]; else r[i] = d[7];
                default: r[i] = d[(i+s)%8];
            endcase
        end
        return r;
    endfunction

    function automatic logic [2:0] modelPe(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            if (d[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic runBeat(input string name, input logic [7:0] data, input logic [2:0] shamt,
                           input logic [1:0] mode, input logic [3:0] tag, input logic [7:0] exp_sh,
                           input logic [2:0] exp_pe, input logic exp_vld);
        applyStimulus(1'b1, data, shamt, mode, tag);
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 4'h0);
        checkOutput({name, "_valid_early"}, bus8.out_valid, 1'b0);
        tick();
        checkOutput({name, "_valid"},   bus8.out_valid,   1'b1);
        checkOutput({name, "_shifted"}, bus8.out_shifted, exp_sh);
        checkOutput({name, "_pe"},      bus8.out_pe,      exp_pe);
        checkOutput({name, "_pe_vld"},  bus8.out_pe_vld,  exp_vld);
        checkOutput({name, "_tag"},     bus8.out_tag,     tag);
        tick();
    endtask

    initial begin
        logic       v;
        logic [7:0] d;
        logic [2:0] s;
        logic [1:0] m;
        logic [3:0] t;
        beat_t      e;
        int         sent;
        int         recv;
        int         cyc;

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 4'h0);
        bus8.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.in_data   = 16'h0000;
        bus16.in_shamt  = 4'd0;
        bus16.in_mode   = 2'b00;
        bus16.in_tag    = 4'h0;
        bus16.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_out_valid",  bus8.out_valid,   1'b0);
        checkOutput("rst_in_ready",   bus8.in_ready,    1'b1);
        checkOutput("rst_shifted",    bus8.out_shifted, 8'h00);
        checkOutput("rst_pe",         bus8.out_pe,      3'd0);
        checkOutput("rst_pe_vld",     bus8.out_pe_vld,  1'b0);
        checkOutput("rst_tag",        bus8.out_tag,     4'h0);

        $display("[TB] directed single beats");
        runBeat("sll_81_1",  8'h81, 3'd1, 2'b00, 4'h3, 8'h02, 3'd1, 1'b1);
        runBeat("sra_80_3",  8'h80, 3'd3, 2'b10, 4'h5, 8'hF0, 3'd7, 1'b1);
        runBeat("sra_40_3",  8'h40, 3'd3, 2'b10, 4'h6, 8'h08, 3'd3, 1'b1);
        runBeat("ror_01_1",  8'h01, 3'd1, 2'b11, 4'h7, 8'h80, 3'd7, 1'b1);
        runBeat("srl_01_1",  8'h01, 3'd1, 2'b01, 4'h8, 8'h00, 3'd0, 1'b0);
        runBeat("sll_a5_0",  8'hA5, 3'd0, 2'b00, 4'h9, 8'hA5, 3'd7, 1'b1);
        runBeat("srl_a5_0",  8'hA5, 3'd0, 2'b01, 4'hA, 8'hA5, 3'd7, 1'b1);
        runBeat("sra_a5_0",  8'hA5, 3'd0, 2'b10, 4'hB, 8'hA5, 3'd7, 1'b1);
        runBeat("ror_a5_0",  8'hA5, 3'd0, 2'b11, 4'hC, 8'hA5, 3'd7, 1'b1);
        runBeat("srl_f0_4",  8'hF0, 3'd4, 2'b01, 4'hD, 8'h0F, 3'd3, 1'b1);
        runBeat("ror_0b_2",  8'h0B, 3'd2, 2'b11, 4'hE, 8'hC2, 3'd7, 1'b1);
        runBeat("sll_ff_7",  8'hFF, 3'd7, 2'b00, 4'hF, 8'h80, 3'd7, 1'b1);
        runBeat("sra_7f_7",  8'h7F, 3'd7, 2'b10, 4'h1, 8'h00, 3'd0, 1'b0);
        runBeat("sra_81_7",  8'h81, 3'd7, 2'b10, 4'h2, 8'hFF, 3'd7, 1'b1);

        $display("[TB] backpressure");
        bus8.out_ready = 1'b0;
        applyStimulus(1'b1, 8'h11, 3'd0, 2'b00, 4'h1);
        tick();
        checkOutput("bp_ready_after_1", bus8.in_ready, 1'b1);
        applyStimulus(1'b1, 8'h12, 3'd0, 2'b00, 4'h2);
        tick();
        checkOutput("bp_ready_after_2", bus8.in_ready,  1'b0);
        checkOutput("bp_valid_2",       bus8.out_valid, 1'b1);
        checkOutput("bp_tag_2",         bus8.out_tag,   4'h1);
        applyStimulus(1'b1, 8'h13, 3'd0, 2'b00, 4'h3);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_hold_ready",   bus8.in_ready,    1'b0);
            checkOutput("bp_hold_valid",   bus8.out_valid,   1'b1);
            checkOutput("bp_hold_tag",     bus8.out_tag,     4'h1);
            checkOutput("bp_hold_shifted", bus8.out_shifted, 8'h11);
        end
        bus8.out_ready = 1'b1;
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 4'h0);
        checkOutput("bp_drain_valid_2", bus8.out_valid,   1'b1);
        checkOutput("bp_drain_tag_2",   bus8.out_tag,     4'h2);
        checkOutput("bp_drain_sh_2",    bus8.out_shifted, 8'h12);
        tick();
        checkOutput("bp_drain_valid_3", bus8.out_valid,   1'b1);
        checkOutput("bp_drain_tag_3",   bus8.out_tag,     4'h3);
        checkOutput("bp_drain_sh_3",    bus8.out_shifted, 8'h13);
        tick();
        checkOutput("bp_drain_empty",   bus8.out_valid,   1'b0);

        $display("[TB] random stream");
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 64 && cyc < 3000) begin
            v = (sent < 64) && ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            s = 3'($urandom_range(0, 7));
            m = 2'($urandom_range(0, 3));
            t = 4'($urandom);
            applyStimulus(v, d, s, m, t);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus8.in_valid && bus8.in_ready) begin
                e.sh  = modelShift(d, int'(s), m);
                e.pe  = modelPe(e.sh);
                e.vld = (e.sh != 8'h00);
                e.tag = t;
                sb.push_back(e);
                sent++;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("stream_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("stream_shifted", bus8.out_shifted, e.sh);
                    checkOutput("stream_pe",      bus8.out_pe,      e.pe);
                    checkOutput("stream_pe_vld",  bus8.out_pe_vld,  e.vld);
                    checkOutput("stream_tag",     bus8.out_tag,     e.tag);
                end
                recv++;
            end
            tick();
            cyc++;
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 4'h0);
        bus8.out_ready = 1'b1;
        checkOutput("stream_received", 32'(recv), 32'd64);
        checkOutput("stream_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        tick();

        $display("[TB] reset with a full pipe");
        bus8.out_ready = 1'b0;
        applyStimulus(1'b1, 8'h55, 3'd1, 2'b00, 4'h4);
        tick();
        applyStimulus(1'b1, 8'h66, 3'd1, 2'b00, 4'h5);
        tick();
        checkOutput("full_valid", bus8.out_valid, 1'b1);
        checkOutput("full_ready", bus8.in_ready,  1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h77, 3'd0, 2'b00, 4'h6);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 4'h0);
        checkOutput("mid_rst_out_valid", bus8.out_valid,   1'b0);
        checkOutput("mid_rst_in_ready",  bus8.in_ready,    1'b1);
        checkOutput("mid_rst_shifted",   bus8.out_shifted, 8'h00);
        checkOutput("mid_rst_pe",        bus8.out_pe,      3'd0);
        checkOutput("mid_rst_pe_vld",    bus8.out_pe_vld,  1'b0);
        checkOutput("mid_rst_tag",       bus8.out_tag,     4'h0);
        bus8.out_ready = 1'b1;
        tick();
        checkOutput("mid_rst_no_ghost_1", bus8.out_valid, 1'b0);
        tick();
        checkOutput("mid_rst_no_ghost_2", bus8.out_valid, 1'b0);

        $display("[TB] 16-bit instance");
        bus16.in_valid = 1'b1;
        bus16.in_data  = 16'h0001;
        bus16.in_shamt = 4'd15;
        bus16.in_mode  = 2'b00;
        bus16.in_tag   = 4'h9;
        tick();
        bus16.in_data  = 16'h8000;
        bus16.in_mode  = 2'b10;
        bus16.in_tag   = 4'hA;
        tick();
        bus16.in_valid = 1'b0;
        checkOutput("w16_sll_valid",   bus16.out_valid,   1'b1);
        checkOutput("w16_sll_shifted", bus16.out_shifted, 16'h8000);
        checkOutput("w16_sll_pe",      bus16.out_pe,      4'd15);
        checkOutput("w16_sll_pe_vld",  bus16.out_pe_vld,  1'b1);
        checkOutput("w16_sll_tag",     bus16.out_tag,     4'h9);
        tick();
        checkOutput("w16_sra_shifted", bus16.out_shifted, 16'hFFFF);
        checkOutput("w16_sra_pe",      bus16.out_pe,      4'd15);
        checkOutput("w16_sra_tag",     bus16.out_tag,     4'hA);
        tick();
        checkOutput("w16_empty",       bus16.out_valid,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
